// File: rtl/srr_pkg.sv
// srr_pkg: shared types and constants for the frame synchroniser.
//   state_e            - FSM encoding (HUNT / LOCKED)
//   SYNC_WORD_DEFAULT  - default frame-start pattern
//   fifo_aw()          - address width for a power-of-two FIFO depth
package srr_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0]  SYNC_WORD_DEFAULT  = 8'hA5;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  function automatic int unsigned fifo_aw(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned FIFO_AW_DEFAULT = fifo_aw(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/srr_byte_fifo.sv
// srr_byte_fifo: first-word fall-through byte FIFO.
//   clk, rst_n : clock, async active-low reset (contents discarded)
//   push_i     : write wdata_i; accepted when not full, or when full and a
//                pop happens on the same edge
//   pop_i      : remove head; ignored while empty
//   rdata_o    : head byte; holds the last popped byte while empty
//   full_o, empty_o : occupancy flags
module srr_byte_fifo
  import srr_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  // Pointers carry one wrap bit above the address for full/empty detection.
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;
  logic [AW-1:0] waddr, raddr;

  assign waddr   = wptr_q[AW-1:0];
  assign raddr   = rptr_q[AW-1:0];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot freed by a same-edge pop is the one being written.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = last_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
      last_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= 8'h00;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[waddr] <= wdata_i;
  end

  assign rdata_o = empty_o ? last_q : mem_q[raddr];

endmodule

// File: rtl/srr_frame_sync.sv
// srr_frame_sync: hunts for SYNC_WORD in the shift-register window, then
// captures FRAME_BYTES byte-aligned payload bytes into an output FIFO.
//   clk, rst_n      : clock, async active-low reset
//   win[7:0]        : shift-register window, win[0] newest bit
//   byte_data/valid : FIFO head (first-word fall-through)
//   byte_ready      : consumer pops head when byte_valid is high
//   locked          : frame in progress
//   overflow        : sticky, set when a captured byte found the FIFO full
//   ovf_clr         : synchronous clear of overflow (a same-edge drop wins)
//   frame_cnt[15:0] : completed frames, only when SRR_FRAME_CNT_EN is defined
//
// state  | meaning
// HUNT   | comparing win against SYNC_WORD every edge
// LOCKED | counting bits; every 8th edge captures win as a payload byte
module srr_frame_sync
  import srr_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int unsigned FRAME_BYTES = 4,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  win,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        locked,
  output logic        overflow,
  input  logic        ovf_clr
`ifdef SRR_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BYTES);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       overflow_q, overflow_d;
  logic       capture, frame_done, drop;
  logic       fifo_full, fifo_empty, pop;

  assign byte_valid = !fifo_empty;
  assign pop        = byte_valid && byte_ready;
  assign drop       = capture && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      HUNT: begin
        if (win == SYNC_WORD) begin
          state_d    = LOCKED;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // Counted even when the byte is dropped so alignment is kept.
          capture    = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_d == FRAME_LAST) begin
            state_d    = HUNT;
            frame_done = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign overflow = overflow_q;

`ifdef SRR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_cnt_q <= 16'h0000;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
`endif

  srr_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (capture),
    .wdata_i (win),
    .pop_i   (pop),
    .rdata_o (byte_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_srr_frame_sync.sv
// Bench for srr_frame_sync. Two instances share clk and the serial window:
// dut_a (FRAME_BYTES=4) and dut_b (FRAME_BYTES=6); the idle one is held in
// reset. Expected bytes are queued when driven and compared when popped.
module tb_srr_frame_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, sel, rdy, ovf_clr;
  logic [7:0] win;
  logic [7:0] data_a, data_b, data_m;
  logic       va, vb, la, lb, oa, ob, valid_m, locked_m, ovf_m, rdy_a, rdy_b;
`ifdef SRR_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  assign valid_m  = sel ? vb : va;
  assign data_m   = sel ? data_b : data_a;
  assign locked_m = sel ? lb : la;
  assign ovf_m    = sel ? ob : oa;
  assign rdy_a    = sel ? 1'b0 : rdy;
  assign rdy_b    = sel ? rdy : 1'b0;

  srr_frame_sync #(.SYNC_WORD(8'hA5), .FRAME_BYTES(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .win(win), .byte_data(data_a), .byte_valid(va),
    .byte_ready(rdy_a), .locked(la), .overflow(oa), .ovf_clr(ovf_clr)
`ifdef SRR_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  srr_frame_sync #(.SYNC_WORD(8'hA5), .FRAME_BYTES(6), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .win(win), .byte_data(data_b), .byte_valid(vb),
    .byte_ready(rdy_b), .locked(lb), .overflow(ob), .ovf_clr(ovf_clr)
`ifdef SRR_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift one bit in at the falling edge; a pop scheduled for the coming
  // rising edge is scored here, then return 1 time unit after that edge.
  task automatic tick(input logic b);
    logic [7:0] e;
    @(negedge clk);
    win = {win[6:0], b};
    if (valid_m && rdy) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_underflow observed=%02h expected=none", data_m);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_data", {24'h0, data_m}, {24'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  task automatic send_payload(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    send_byte(b);
  endtask

  initial begin
    logic [7:0] f1 [4];
    f1 = '{8'h12, 8'h34, 8'h56, 8'h78};
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0; rdy = 1'b0; ovf_clr = 1'b0; win = 8'h00;
    #12;
    chk("rst_valid", va, 0);
    chk("rst_data", data_a, 8'h00);
    chk("rst_locked", la, 0);
    chk("rst_overflow", oa, 0);
    chk("rst_b_valid", vb, 0);
    @(negedge clk); rst_a = 1'b1;

    // Sync then payload, consumer always ready.
    rdy = 1'b1;
    send_byte(8'hA5);
    chk("t1_locked", locked_m, 1);
    for (int i = 0; i < 4; i++) begin
      send_payload(f1[i], 1'b1);
      chk("t1_valid_after_capture", valid_m, 1);
      chk("t1_head", data_m, f1[i]);
      chk("t1_locked_state", locked_m, (i < 3) ? 1 : 0);
    end
    send_byte(8'h00);
    chk("t1_drained", valid_m, 0);

    // Sync patterns inside the payload are plain data.
    send_byte(8'hA5);
    send_payload(8'hA5, 1'b1);
    chk("t2_still_locked", locked_m, 1);
    send_payload(8'h5A, 1'b1);
    send_payload(8'hA5, 1'b1);
    chk("t2_no_relock", locked_m, 1);
    send_payload(8'h00, 1'b1);
    chk("t2_unlocked", locked_m, 0);
    send_byte(8'h00);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Backpressure on the 6-byte instance.
    rst_a = 1'b0; rst_b = 1'b1; sel = 1'b1; rdy = 1'b0;
    send_byte(8'hA5);
    send_payload(8'h11, 1'b1);
    send_payload(8'h22, 1'b1);
    send_payload(8'h33, 1'b1);
    send_payload(8'h44, 1'b1);
    chk("t3_ovf_at_full", ovf_m, 0);
    chk("t3_head_held", data_m, 8'h11);
    send_payload(8'h55, 1'b0);
    chk("t3_ovf_set", ovf_m, 1);
    chk("t3_locked_5", locked_m, 1);
    send_payload(8'h66, 1'b0);
    chk("t3_unlocked", locked_m, 0);
    chk("t3_ovf_sticky", ovf_m, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("t3_ovf_cleared", ovf_m, 0);
    ovf_clr = 1'b0;
    rdy = 1'b1;
    repeat (6) tick(1'b0);
    chk("t3_drained", valid_m, 0);
    chk("t3_empty_holds", data_m, 8'h44);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Full FIFO with a pop exactly on the capture edge.
    rdy = 1'b0;
    send_byte(8'hA5);
    for (int i = 1; i <= 4; i++) send_payload(8'hC0 + 8'(i), 1'b1);
    exp_q.push_back(8'hC5);
    for (int i = 7; i >= 1; i--) tick(1'(8'hC5 >> i));
    rdy = 1'b1;
    tick(1'b1);
    rdy = 1'b0;
    chk("t4_ovf_clear", ovf_m, 0);
    chk("t4_new_head", data_m, 8'hC2);
    // Drop and clear on the same edge: the drop wins.
    for (int i = 7; i >= 1; i--) tick(1'(8'hC6 >> i));
    ovf_clr = 1'b1;
    tick(1'b0);
    ovf_clr = 1'b0;
    chk("t4_set_wins", ovf_m, 1);
    chk("t4_unlocked", locked_m, 0);
    rdy = 1'b1;
    repeat (6) tick(1'b0);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame.
    rst_b = 1'b0; sel = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    send_byte(8'hA5);
    send_payload(8'h12, 1'b1);
    send_payload(8'h34, 1'b1);
    tick(1'b0); tick(1'b1); tick(1'b0);
    #1 rst_a = 1'b0;
    #1;
    chk("t5_rst_valid", valid_m, 0);
    chk("t5_rst_locked", locked_m, 0);
    #1 rst_a = 1'b1;
    chk("t5_queue_empty", exp_q.size(), 0);
    send_byte(8'h00);
    send_byte(8'hA5);
    chk("t5_relocked", locked_m, 1);
    send_payload(8'h9A, 1'b1);
    send_payload(8'hBC, 1'b1);
    send_payload(8'hDE, 1'b1);
    send_payload(8'hF0, 1'b1);
    chk("t5_unlocked", locked_m, 0);
    send_byte(8'h00);
    chk("t5_queue_drained", exp_q.size(), 0);

`ifdef SRR_FRAME_CNT_EN
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    chk("t6_cnt_reset", fc_a, 16'd0);
    for (int f = 0; f < 3; f++) begin
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_payload(8'h00, 1'b1);
    end
    chk("t6_frame_cnt", fc_a, 16'd3);
    chk("t6_b_cnt", fc_b, 16'd0);
    send_byte(8'h00);
    chk("t6_queue_drained", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
